// File: rtl/mod_74x161_n.sv
// Cascade of STAGES 74x161-style 4-bit synchronous counters forming a (4*STAGES)-bit counter.
// Define MOD_74X161_N_UPDOWN_EN to add the UP port for up/down counting.
module mod_74x161_n #(
    parameter int STAGES = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  LOAD_n,
    input  logic                  ENP,
    input  logic                  ENT,
`ifdef MOD_74X161_N_UPDOWN_EN
    input  logic                  UP,
`endif
    input  logic [4*STAGES-1:0]   D,
    output logic [4*STAGES-1:0]   Q,
    output logic [STAGES-1:0]     RCO_STAGE,
    output logic                  RCO
);

    logic              up_dir;
    logic [3:0]        term_val;
    logic [STAGES-1:0] stage_tc;
    logic [STAGES-1:0] stage_ent;
    logic [STAGES-1:0] stage_rco;

`ifdef MOD_74X161_N_UPDOWN_EN
    assign up_dir = UP;
`else
    assign up_dir = 1'b1;
`endif

    // Terminal count is 15 when counting up and 0 when counting down.
    assign term_val = up_dir ? 4'hF : 4'h0;

    // Carry chain walked with a local accumulator: each stage's ENT is the previous stage's RCO.
    always_comb begin
        logic ent_acc;
        stage_ent = '0;
        stage_rco = '0;
        ent_acc   = ENT;
        for (int k = 0; k < STAGES; k++) begin
            stage_ent[k] = ent_acc;
            stage_rco[k] = ent_acc & stage_tc[k];
            ent_acc      = stage_rco[k];
        end
    end

    // Carries are forced low while reset is held, even if the reset value is a terminal count.
    assign RCO_STAGE = stage_rco & {STAGES{~RST}};
    assign RCO       = RCO_STAGE[STAGES-1];

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [3:0] stage_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    stage_q <= 4'h0;
                end else if (!LOAD_n) begin
                    stage_q <= D[4*k +: 4];
                end else if (ENP && stage_ent[k]) begin
                    stage_q <= up_dir ? stage_q + 4'd1 : stage_q - 4'd1;
                end
            end

            assign stage_tc[k]  = (stage_q == term_val);
            assign Q[4*k +: 4]  = stage_q;
        end
    endgenerate

endmodule

// File: tb/tb_mod_74x161_n.sv
// Bench for mod_74x161_n: 2-stage and 3-stage instances against an arithmetic reference model.
// Build with MOD_74X161_N_UPDOWN_EN defined to also exercise down counting.
module tb_mod_74x161_n;

    logic        CLK = 1'b0;
    logic        RST;
    logic        LOAD_n;
    logic        ENP;
    logic        ENT;
    logic        UP;
    logic [7:0]  D8;
    logic [7:0]  Q8;
    logic [1:0]  rs8;
    logic        rco8;
    logic [11:0] D12;
    logic [11:0] Q12;
    logic [2:0]  rs12;
    logic        rco12;

    int n_tests = 0;
    int n_fail  = 0;
    int m8      = 0;
    int m12     = 0;
    logic [7:0]  exp_q[$];
    logic [11:0] exp_q12[$];

    // clock / reset block
    always #5 CLK = ~CLK;

    mod_74x161_n #(.STAGES(2)) dut2 (
        .CLK(CLK), .RST(RST), .LOAD_n(LOAD_n), .ENP(ENP), .ENT(ENT),
`ifdef MOD_74X161_N_UPDOWN_EN
        .UP(UP),
`endif
        .D(D8), .Q(Q8), .RCO_STAGE(rs8), .RCO(rco8)
    );

    mod_74x161_n #(.STAGES(3)) dut3 (
        .CLK(CLK), .RST(RST), .LOAD_n(LOAD_n), .ENP(ENP), .ENT(ENT),
`ifdef MOD_74X161_N_UPDOWN_EN
        .UP(UP),
`endif
        .D(D12), .Q(Q12), .RCO_STAGE(rs12), .RCO(rco12)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stage k carries when ENT is high and all low 4*(k+1) bits sit at the terminal value.
    function automatic logic [31:0] exp_rs(input int q, input int stages, input logic ent, input logic up);
        logic [31:0] r = '0;
        for (int k = 0; k < stages; k++) begin
            int mask = (1 << (4 * (k + 1))) - 1;
            if (ent && (up ? ((q & mask) == mask) : ((q & mask) == 0))) r[k] = 1'b1;
        end
        return r;
    endfunction

    function automatic int model_next(input int q, input int modulus, input logic ld, input logic p,
                                      input logic t, input logic up, input int d);
        if (!ld) return d;
        if (p && t) return up ? (q + 1) % modulus : (q + modulus - 1) % modulus;
        return q;
    endfunction

    // Called just after a falling edge: drive, check carries, then check Q after the next rising edge.
    task automatic step(input logic ld, input logic p, input logic t, input logic u,
                        input logic [7:0] d8, input logic [11:0] d12);
        logic [31:0] e8;
        logic [31:0] e12;
        LOAD_n = ld; ENP = p; ENT = t; UP = u; D8 = d8; D12 = d12;
        #1;
        e8  = exp_rs(m8, 2, t, u);
        e12 = exp_rs(m12, 3, t, u);
        check_val("rco_stage8", {30'd0, rs8}, e8);
        check_val("rco8", {31'd0, rco8}, {31'd0, e8[1]});
        check_val("rco_stage12", {29'd0, rs12}, e12);
        check_val("rco12", {31'd0, rco12}, {31'd0, e12[2]});
        m8  = model_next(m8, 256, ld, p, t, u, int'(d8));
        m12 = model_next(m12, 4096, ld, p, t, u, int'(d12));
        exp_q.push_back(m8[7:0]);
        exp_q12.push_back(m12[11:0]);
        @(negedge CLK);
        check_val("q8", {24'd0, Q8}, {24'd0, exp_q.pop_front()});
        check_val("q12", {20'd0, Q12}, {20'd0, exp_q12.pop_front()});
    endtask

    // Asynchronous reset pulse entirely between clock edges.
    task automatic reset_pulse();
        #1 RST = 1'b1;
        #1;
        check_val("rst_q8", {24'd0, Q8}, 32'd0);
        check_val("rst_q12", {20'd0, Q12}, 32'd0);
        check_val("rst_rco_stage8", {30'd0, rs8}, 32'd0);
        check_val("rst_rco8", {31'd0, rco8}, 32'd0);
        check_val("rst_rco12", {31'd0, rco12}, 32'd0);
        #1 RST = 1'b0;
        m8  = 0;
        m12 = 0;
    endtask

    initial begin
        RST = 1'b1; LOAD_n = 1'b1; ENP = 1'b0; ENT = 1'b0; UP = 1'b1; D8 = '0; D12 = '0;
        @(negedge CLK);
        @(negedge CLK);
        check_val("reset_q8", {24'd0, Q8}, 32'd0);
        check_val("reset_rco8", {31'd0, rco8}, 32'd0);
        RST = 1'b0;

        // async reset from a loaded value, with counting enabled
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 12'h5A5);
        ENP = 1'b1; ENT = 1'b1;
        reset_pulse();
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 12'h000);

        // count through the all-ones wrap
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFD, 12'hFFD);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 12'h000);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 12'h000);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 12'h000);

        // stage-0 carry only at 0F
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h0F, 12'h00F);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 12'h000);

        // hold at all ones: ENP=0 keeps RCO, ENT=0 kills it
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 12'hFFF);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 12'h000);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 12'h000);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 12'h000);

        // load beats count at all ones
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 12'h0FF);
        // three-stage carry across two stages on one edge
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 12'h000);

`ifdef MOD_74X161_N_UPDOWN_EN
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 12'h001);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 12'h000);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 12'h000);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 12'h000);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic       ld;
            logic       p;
            logic       t;
            logic       u;
            logic [7:0]  d8;
            logic [11:0] d12;
            ld  = ($urandom_range(0, 7) != 0);
            p   = ($urandom_range(0, 3) != 0);
            t   = ($urandom_range(0, 4) != 0);
`ifdef MOD_74X161_N_UPDOWN_EN
            u   = ($urandom_range(0, 9) != 0) ? UP : ~UP;
`else
            u   = 1'b1;
`endif
            d8  = 8'($urandom_range(0, 255));
            d12 = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 0) begin
                d8  = {4'hF, d8[3:0]};
                d12 = {8'hFF, d12[3:0]};
            end
            if ($urandom_range(0, 40) == 0) reset_pulse();
            step(ld, p, t, u, d8, d12);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
